// File: rtl/superscalar_processor.sv
// Two-way in-order superscalar core with internal unified MEM and REG arrays.
// Define SSP_DUAL_ISSUE_EN to enable pairing of slot1; otherwise the core is scalar.
module superscalar_processor (
    input logic clk1,
    input logic reset
);
    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_MUL  = 6'b000010;
    localparam logic [5:0] OP_AND  = 6'b000011;
    localparam logic [5:0] OP_OR   = 6'b000100;
    localparam logic [5:0] OP_XOR  = 6'b000101;
    localparam logic [5:0] OP_SLL  = 6'b000110;
    localparam logic [5:0] OP_SRL  = 6'b000111;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SUBI = 6'b001001;
    localparam logic [5:0] OP_ANDI = 6'b001010;
    localparam logic [5:0] OP_ORI  = 6'b001011;
    localparam logic [5:0] OP_XORI = 6'b001100;
    localparam logic [5:0] OP_LW   = 6'b010000;
    localparam logic [5:0] OP_SW   = 6'b010001;
    localparam logic [5:0] OP_BEQ  = 6'b011000;
    localparam logic [5:0] OP_BNE  = 6'b011001;
    localparam logic [5:0] OP_BLT  = 6'b011010;
    localparam logic [5:0] OP_BGE  = 6'b011011;
    localparam logic [5:0] OP_J    = 6'b100000;
    localparam logic [5:0] OP_JAL  = 6'b100001;

    logic [31:0] MEM [0:1023];
    logic [31:0] REG [0:31];
    logic [9:0]  PC;

    logic [31:0] inst   [2];
    logic        wen    [2];
    logic [4:0]  wa     [2];
    logic [31:0] wd     [2];
    logic        men    [2];
    logic [9:0]  maddr  [2];
    logic [31:0] mdat   [2];
    logic        ctl    [2];
    logic        taken  [2];
    logic [9:0]  tgt    [2];
    logic        is_mem [2];
    logic        rd_rs  [2];
    logic        rd_rt  [2];
    logic        dual;
    logic [9:0]  pc_d;

    assign inst[0] = MEM[PC];
    assign inst[1] = MEM[PC + 10'd1];

    // Both slots decode from pre-edge state, so slot1 never sees slot0's result.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            logic [5:0]  op;
            logic [4:0]  rs, rt, rd;
            logic [15:0] imm;
            logic [31:0] a, b, simm, zimm;
            logic [9:0]  ea, pc_s;
            op   = inst[s][31:26];
            rs   = inst[s][25:21];
            rt   = inst[s][20:16];
            rd   = inst[s][15:11];
            imm  = inst[s][15:0];
            a    = (rs == 5'd0) ? 32'd0 : REG[rs];
            b    = (rt == 5'd0) ? 32'd0 : REG[rt];
            simm = {{16{imm[15]}}, imm};
            zimm = {16'd0, imm};
            ea   = a[9:0] + imm[9:0];
            pc_s = PC + 10'(s);

            wen[s]    = 1'b0;
            wa[s]     = rd;
            wd[s]     = 32'd0;
            men[s]    = 1'b0;
            maddr[s]  = ea;
            mdat[s]   = b;
            ctl[s]    = 1'b0;
            taken[s]  = 1'b0;
            tgt[s]    = pc_s + 10'd1 + imm[9:0];
            is_mem[s] = 1'b0;
            rd_rs[s]  = 1'b0;
            rd_rt[s]  = 1'b0;

            case (op)
                OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL: begin
                    wen[s]   = 1'b1;
                    rd_rs[s] = 1'b1;
                    rd_rt[s] = 1'b1;
                    case (op)
                        OP_ADD:  wd[s] = a + b;
                        OP_SUB:  wd[s] = a - b;
                        OP_MUL:  wd[s] = a * b;
                        OP_AND:  wd[s] = a & b;
                        OP_OR:   wd[s] = a | b;
                        OP_XOR:  wd[s] = a ^ b;
                        OP_SLL:  wd[s] = a << b[4:0];
                        default: wd[s] = a >> b[4:0];
                    endcase
                end
                OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_XORI: begin
                    wen[s]   = 1'b1;
                    wa[s]    = rt;
                    rd_rs[s] = 1'b1;
                    case (op)
                        OP_ADDI: wd[s] = a + simm;
                        OP_SUBI: wd[s] = a - simm;
                        OP_ANDI: wd[s] = a & zimm;
                        OP_ORI:  wd[s] = a | zimm;
                        default: wd[s] = a ^ zimm;
                    endcase
                end
                OP_LW: begin
                    wen[s]    = 1'b1;
                    wa[s]     = rt;
                    wd[s]     = MEM[ea];
                    is_mem[s] = 1'b1;
                    rd_rs[s]  = 1'b1;
                end
                OP_SW: begin
                    men[s]    = 1'b1;
                    is_mem[s] = 1'b1;
                    rd_rs[s]  = 1'b1;
                    rd_rt[s]  = 1'b1;
                end
                OP_BEQ, OP_BNE, OP_BLT, OP_BGE: begin
                    ctl[s]   = 1'b1;
                    rd_rs[s] = 1'b1;
                    rd_rt[s] = 1'b1;
                    case (op)
                        OP_BEQ:  taken[s] = (a == b);
                        OP_BNE:  taken[s] = (a != b);
                        OP_BLT:  taken[s] = ($signed(a) < $signed(b));
                        default: taken[s] = ($signed(a) >= $signed(b));
                    endcase
                end
                OP_J, OP_JAL: begin
                    ctl[s]   = 1'b1;
                    taken[s] = 1'b1;
                    tgt[s]   = inst[s][9:0];
                    if (op == OP_JAL) begin
                        wen[s] = 1'b1;
                        wa[s]  = 5'd31;
                        wd[s]  = {22'd0, pc_s + 10'd1};
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SSP_DUAL_ISSUE_EN
    logic raw_hit;
    logic hazard;
    assign raw_hit = wen[0] && (wa[0] != 5'd0) &&
                     ((rd_rs[1] && (inst[1][25:21] == wa[0])) ||
                      (rd_rt[1] && (inst[1][20:16] == wa[0])));
    assign hazard  = ctl[0] || ctl[1] || (is_mem[0] && is_mem[1]) || raw_hit ||
                     (wen[0] && wen[1] && (wa[0] == wa[1]));
    assign dual    = !hazard;
`else
    assign dual    = 1'b0;
`endif

    always_comb begin
        if (taken[0])
            pc_d = tgt[0];
        else if (dual)
            pc_d = PC + 10'd2;
        else
            pc_d = PC + 10'd1;
    end

    // Arrays share the async-reset block so an edge with reset high never writes.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            PC <= 10'd0;
        end else begin
            PC <= pc_d;
            if (wen[0] && (wa[0] != 5'd0))
                REG[wa[0]] <= wd[0];
            if (dual && wen[1] && (wa[1] != 5'd0))
                REG[wa[1]] <= wd[1];
            if (men[0])
                MEM[maddr[0]] <= mdat[0];
            else if (dual && men[1])
                MEM[maddr[1]] <= mdat[1];
        end
    end
endmodule

// File: tb/tb_superscalar_processor.sv
// Self-checking bench for superscalar_processor: ALU vector table plus program sequences.
module tb_superscalar_processor;
    logic clk1 = 1'b0;
    logic reset = 1'b1;

    superscalar_processor dut (
        .clk1  (clk1),
        .reset (reset)
    );

    always #5 clk1 = ~clk1;

`ifdef SSP_DUAL_ISSUE_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    localparam logic [31:0] NOP = 32'hFC00_0000;
    localparam int K_REG = 0;
    localparam int K_MEM = 1;
    localparam int K_PC  = 2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        int          kind;
        int          idx;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] a;
        logic [31:0] b;
        int          dst;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[16];

    function automatic logic [31:0] rtype(logic [5:0] op, int rd, int rs, int rt);
        return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
    endfunction

    function automatic logic [31:0] itype(logic [5:0] op, int rt, int rs, logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    task automatic expect_val(string n, int k, int i, logic [31:0] e);
        exp_t x;
        x.name = n; x.kind = k; x.idx = i; x.exp = e;
        sb.push_back(x);
    endtask

    task automatic drain();
        exp_t x;
        logic [31:0] act;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            case (x.kind)
                K_REG:   act = dut.REG[x.idx];
                K_MEM:   act = dut.MEM[x.idx];
                default: act = {22'd0, dut.PC};
            endcase
            checks++;
            if (act !== x.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", x.name, act, x.exp);
            end
        end
    endtask

    task automatic start_prog();
        reset = 1'b1;
        @(negedge clk1);
        for (int i = 0; i < 1024; i++) dut.MEM[i] = NOP;
    endtask

    task automatic release_rst();
        @(negedge clk1);
        reset = 1'b0;
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clk1);
        #1;
    endtask

    initial begin
        vecs[0]  = '{"add",   rtype(6'b000000, 3, 1, 2), 32'd5, 32'd7, 3, 32'd12};
        vecs[1]  = '{"sub",   rtype(6'b000001, 3, 1, 2), 32'd5, 32'd7, 3, 32'hFFFF_FFFE};
        vecs[2]  = '{"mul",   rtype(6'b000010, 3, 1, 2), 32'h0001_0000, 32'h0003_0003, 3, 32'h0003_0000};
        vecs[3]  = '{"and",   rtype(6'b000011, 3, 1, 2), 32'h0000_F0F0, 32'h0000_FF00, 3, 32'h0000_F000};
        vecs[4]  = '{"or",    rtype(6'b000100, 3, 1, 2), 32'h0000_F0F0, 32'h0000_FF00, 3, 32'h0000_FFF0};
        vecs[5]  = '{"xor",   rtype(6'b000101, 3, 1, 2), 32'h0000_F0F0, 32'h0000_FF00, 3, 32'h0000_0FF0};
        vecs[6]  = '{"sll",   rtype(6'b000110, 3, 1, 2), 32'd1, 32'h25, 3, 32'd32};
        vecs[7]  = '{"srl",   rtype(6'b000111, 3, 1, 2), 32'h8000_0000, 32'd4, 3, 32'h0800_0000};
        vecs[8]  = '{"addi",  itype(6'b001000, 3, 1, 16'hFFFF), 32'd10, 32'd0, 3, 32'd9};
        vecs[9]  = '{"subi",  itype(6'b001001, 3, 1, 16'd3), 32'd10, 32'd0, 3, 32'd7};
        vecs[10] = '{"andi",  itype(6'b001010, 3, 1, 16'h8001), 32'hFFFF_FFFF, 32'd0, 3, 32'h0000_8001};
        vecs[11] = '{"ori",   itype(6'b001011, 3, 1, 16'h8000), 32'hF000_0000, 32'd0, 3, 32'hF000_8000};
        vecs[12] = '{"xori",  itype(6'b001100, 3, 1, 16'hFFFF), 32'hFFFF_0000, 32'd0, 3, 32'hFFFF_FFFF};
        vecs[13] = '{"add_r0", rtype(6'b000000, 0, 1, 2), 32'd5, 32'd7, 0, 32'd0};
        vecs[14] = '{"undef", rtype(6'b110000, 3, 1, 2), 32'd5, 32'd7, 3, 32'hDEAD_BEEF};
        vecs[15] = '{"srl_big", rtype(6'b000111, 3, 1, 2), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 32'h0000_0001};

        #30;

        // Load program from the plan; edge count differs between builds.
        start_prog();
        expect_val("reset_pc", K_PC, 0, 32'd0);
        drain();
        dut.MEM[1]  = itype(6'b010000, 1, 0, 16'd50);
        dut.MEM[2]  = itype(6'b010000, 3, 0, 16'd80);
        dut.MEM[4]  = itype(6'b010000, 2, 0, 16'd40);
        dut.MEM[40] = 32'd100;
        dut.MEM[50] = 32'd100;
        dut.MEM[80] = 32'd100;
        dut.REG[0] = 0; dut.REG[1] = 0; dut.REG[2] = 0; dut.REG[3] = 0;
        release_rst();
        step(DUAL ? 3 : 5);
        expect_val("loads_r1", K_REG, 1, 32'd100);
        expect_val("loads_r2", K_REG, 2, 32'd100);
        expect_val("loads_r3", K_REG, 3, 32'd100);
        expect_val("loads_pc", K_PC, 0, DUAL ? 32'd6 : 32'd5);
        drain();

        for (int v = 0; v < 16; v++) begin
            start_prog();
            dut.MEM[0] = vecs[v].instr;
            dut.REG[0] = 32'd0;
            dut.REG[1] = vecs[v].a;
            dut.REG[2] = vecs[v].b;
            dut.REG[3] = 32'hDEAD_BEEF;
            release_rst();
            expect_val({vecs[v].name, "_res"}, K_REG, vecs[v].dst, vecs[v].exp);
            expect_val({vecs[v].name, "_pc"}, K_PC, 0, DUAL ? 32'd2 : 32'd1);
            step(1);
            drain();
        end

        // Slot1 reads slot0's destination, so it must wait one edge.
        start_prog();
        dut.MEM[0] = itype(6'b001000, 1, 0, 16'd5);
        dut.MEM[1] = rtype(6'b000000, 2, 1, 1);
        dut.REG[1] = 0; dut.REG[2] = 0;
        release_rst();
        step(1);
        expect_val("raw_r1", K_REG, 1, 32'd5);
        expect_val("raw_r2_held", K_REG, 2, 32'd0);
        expect_val("raw_pc1", K_PC, 0, 32'd1);
        drain();
        step(1);
        expect_val("raw_r2", K_REG, 2, 32'd10);
        expect_val("raw_pc2", K_PC, 0, DUAL ? 32'd3 : 32'd2);
        drain();

        start_prog();
        dut.MEM[0]   = itype(6'b001000, 4, 0, 16'd7);
        dut.MEM[1]   = itype(6'b010001, 4, 0, 16'd100);
        dut.MEM[2]   = itype(6'b010000, 5, 0, 16'd100);
        dut.MEM[100] = 32'd0;
        dut.REG[4] = 0; dut.REG[5] = 0;
        release_rst();
        step(3);
        expect_val("st_mem100", K_MEM, 100, 32'd7);
        expect_val("ld_r5", K_REG, 5, 32'd7);
        drain();

        start_prog();
        dut.MEM[0] = itype(6'b001001, 1, 1, 16'd1);
        dut.MEM[1] = {6'b011001, 5'd1, 5'd0, 16'hFFFE};
        dut.REG[1] = 32'd3;
        release_rst();
        step(2);
        expect_val("loop_it1_r1", K_REG, 1, 32'd2);
        expect_val("loop_it1_pc", K_PC, 0, 32'd0);
        drain();
        step(4);
        expect_val("loop_r1", K_REG, 1, 32'd0);
        expect_val("loop_pc", K_PC, 0, 32'd2);
        drain();

        start_prog();
        dut.MEM[0]  = {6'b100001, 26'd20};
        dut.MEM[20] = itype(6'b001000, 6, 0, 16'd9);
        dut.REG[31] = 0; dut.REG[6] = 0;
        release_rst();
        step(1);
        expect_val("jal_r31", K_REG, 31, 32'd1);
        expect_val("jal_pc", K_PC, 0, 32'd20);
        drain();
        step(1);
        expect_val("jal_target_exec", K_REG, 6, 32'd9);
        drain();

        // Jump to the last word; the pair there wraps to MEM[0].
        start_prog();
        dut.MEM[0]    = {6'b100000, 26'd1023};
        dut.MEM[1023] = itype(6'b001000, 7, 0, 16'd1);
        dut.REG[7] = 0;
        release_rst();
        step(1);
        expect_val("wrap_jpc", K_PC, 0, 32'd1023);
        drain();
        step(1);
        expect_val("wrap_r7", K_REG, 7, 32'd1);
        expect_val("wrap_pc", K_PC, 0, 32'd0);
        drain();

        start_prog();
        dut.MEM[0] = itype(6'b001001, 1, 1, 16'd1);
        dut.MEM[1] = {6'b011001, 5'd1, 5'd0, 16'hFFFE};
        dut.REG[1] = 32'd3;
        release_rst();
        step(3);
        expect_val("mid_pre_pc", K_PC, 0, 32'd1);
        drain();
        #2 reset = 1'b1;
        #1;
        expect_val("mid_async_pc", K_PC, 0, 32'd0);
        expect_val("mid_r1_kept", K_REG, 1, 32'd1);
        drain();
        step(1);
        expect_val("mid_hold_r1", K_REG, 1, 32'd1);
        expect_val("mid_hold_pc", K_PC, 0, 32'd0);
        drain();
        release_rst();
        step(2);
        expect_val("mid_resume_r1", K_REG, 1, 32'd0);
        expect_val("mid_resume_pc", K_PC, 0, 32'd2);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
